// File: rtl/dcache_arbiter_if.sv
// Requester and datacache signal bundle for the two-port datacache arbiter.
// slave is the arbiter's view; master is the requesters plus the cache.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

interface dcache_arbiter_if #(
  parameter int WIDTH = `WORD_SIZE
);
  logic             a_req;
  logic [WIDTH-1:0] a_addr;
  logic             a_ack;
  logic [WIDTH-1:0] a_rdata;
  logic             a_err;
  logic             b_req;
  logic             b_we;
  logic [WIDTH-1:0] b_addr;
  logic [WIDTH-1:0] b_wdata;
  logic             b_ack;
  logic [WIDTH-1:0] b_rdata;
  logic             b_err;
  logic [WIDTH-1:0] cache_addr;
  logic             cache_read;
  logic             cache_write;
  logic [WIDTH-1:0] cache_wdata;
  logic [WIDTH-1:0] cache_rdata;
  logic             cache_over;

  modport slave (
    input  a_req, a_addr, b_req, b_we, b_addr, b_wdata, cache_rdata, cache_over,
    output a_ack, a_rdata, a_err, b_ack, b_rdata, b_err,
           cache_addr, cache_read, cache_write, cache_wdata
  );

  modport master (
    output a_req, a_addr, b_req, b_we, b_addr, b_wdata, cache_rdata, cache_over,
    input  a_ack, a_rdata, a_err, b_ack, b_rdata, b_err,
           cache_addr, cache_read, cache_write, cache_wdata
  );
endinterface

// File: rtl/dcache_arbiter.sv
// Round-robin arbiter/sequencer between instruction fetch (A, read-only) and
// load/store (B) for the shared datacache, with an optional BUSY timeout.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

module dcache_arbiter #(
  parameter int WIDTH   = `WORD_SIZE,
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 9
) (
  input  logic            clk,
  input  logic            rst,
  dcache_arbiter_if.slave bus
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_BUSY    = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;

  logic [1:0]       state;
  logic             last_b;
  logic             win_b;
  logic             win_we;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             grant_b;
  logic             timeout_hit;

  // On a tie the port that did not win last time gets the grant.
  always_comb begin
    grant_b     = bus.b_req && (!bus.a_req || !last_b);
    cnt_inc     = cnt + CNT_W'(1);
    timeout_hit = (TIMEOUT != 0) && (cnt_inc == CNT_W'(TIMEOUT));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      last_b          <= 1'b1;
      win_b           <= 1'b0;
      win_we          <= 1'b0;
      cnt             <= '0;
      bus.cache_read  <= 1'b0;
      bus.cache_write <= 1'b0;
      bus.cache_addr  <= '0;
      bus.cache_wdata <= '0;
      bus.a_ack       <= 1'b0;
      bus.a_err       <= 1'b0;
      bus.a_rdata     <= '0;
      bus.b_ack       <= 1'b0;
      bus.b_err       <= 1'b0;
      bus.b_rdata     <= '0;
    end else begin
      bus.a_ack <= 1'b0;
      bus.a_err <= 1'b0;
      bus.b_ack <= 1'b0;
      bus.b_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.a_req || bus.b_req) begin
            win_b           <= grant_b;
            win_we          <= grant_b && bus.b_we;
            bus.cache_addr  <= grant_b ? bus.b_addr : bus.a_addr;
            if (grant_b && bus.b_we)
              bus.cache_wdata <= bus.b_wdata;
            bus.cache_read  <= !(grant_b && bus.b_we);
            bus.cache_write <= grant_b && bus.b_we;
            cnt             <= '0;
            state           <= S_BUSY;
          end
        end
        S_BUSY: begin
          cnt <= cnt_inc;
          // A completion on the same edge as the timeout wins.
          if (bus.cache_over || timeout_hit) begin
            if (win_b) begin
              bus.b_ack <= 1'b1;
              bus.b_err <= !bus.cache_over;
              if (!bus.cache_over)
                bus.b_rdata <= '0;
              else if (!win_we)
                bus.b_rdata <= bus.cache_rdata;
            end else begin
              bus.a_ack   <= 1'b1;
              bus.a_err   <= !bus.cache_over;
              bus.a_rdata <= bus.cache_over ? bus.cache_rdata : WIDTH'(0);
            end
            bus.cache_read  <= 1'b0;
            bus.cache_write <= 1'b0;
            last_b          <= win_b;
            state           <= S_RELEASE;
          end
        end
        S_RELEASE: state <= S_IDLE;
        default:   state <= S_IDLE;
      endcase
    end
  end

endmodule
